usb_tx_ctrl: RTL and testbench
==============================

# usb_tx_ctrl

Packet-sequencing controller for the USB transmit datapath. It accepts a packet request, then drives the 8-bit parallel-to-serial shifter's load port byte by byte: SYNC, PID, payload popped from the TX FIFO, CRC16, then EOP. It gates the bit-timer and counts its shift strobes to find byte boundaries. It sits inside the TX top level, between the protocol engine/FIFO and the shifter, timer, bit-stuffer and encoder chain.

## Interface
- MAX_PAYLOAD, 64: payload byte limit for DATA0; larger requested sizes are clamped to this value.
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- tx_packet  input  2  request: 00 none, 01 DATA0, 10 ACK, 11 NAK; sampled only in IDLE
- tx_packet_size  input  7  payload byte count for DATA0
- packet_data  input  8  FIFO head byte (first-word-fall-through), valid whenever FIFO non-empty
- shift_strobe  input  1  one-cycle pulse from tx_timer, one per transmitted (non-stuffed) bit
- load_enable  output  1  one-cycle load pulse to shifter
- parallel_out  output  8  byte to shifter, valid while load_enable=1
- timer_enable  output  1  run request to timer (top level ANDs with bit-stuffer hold)
- get_tx_data  output  1  one-cycle FIFO pop, coincident with load of a payload byte
- eop_se0  output  1  force SE0 on the bus (overrides encoder)
- tx_busy  output  1  high in every non-IDLE state
- tx_done  output  1  one-cycle pulse on completion

## Operation
- States: IDLE, LOAD, SEND, EOP_SE0, EOP_J, DONE. A field register (SYNC, PID, DATA, CRC_LO, CRC_HI) selects the byte for LOAD.
- IDLE: if tx_packet≠00, latch the type and the clamped size min(tx_packet_size, MAX_PAYLOAD), reset CRC to 0xFFFF, field=SYNC, go to LOAD.
- LOAD (exactly 1 cycle): load_enable=1 and parallel_out per field:
  - SYNC 0x80
  - PID 0xC3 (DATA0), 0xD2 (ACK), 0x5A (NAK)
  - DATA packet_data, with get_tx_data=1 and CRC updated with packet_data
  - CRC_LO ~crc[7:0]
  - CRC_HI ~crc[15:8]
  - Clear the bit counter, go to SEND.
- SEND: count shift_strobe (3-bit counter). On the 8th strobe, select the next field:
  - SYNC→PID.
  - PID→DATA for DATA0 with size>0; PID→CRC_LO for DATA0 with size=0; PID→EOP_SE0 for ACK/NAK.
  - DATA→DATA while bytes remain, else CRC_LO.
  - CRC_LO→CRC_HI.
  - CRC_HI→EOP_SE0.
  - The next state is LOAD, except EOP_SE0 as listed.
- EOP_SE0: eop_se0=1 for 2 strobes, then EOP_J for 1 strobe (bus J, eop_se0=0), then DONE.
- DONE: tx_done=1 for one cycle, then IDLE.
- timer_enable=1 in LOAD, SEND, EOP_SE0 and EOP_J.
- tx_packet changes while busy are ignored. A new request is accepted no earlier than the cycle after DONE.
- CRC: CRC-16/USB, polynomial 0x8005 reflected (0xA001), init 0xFFFF, data LSB-first, transmitted complemented, low byte first. The CRC register is 16 bits and the byte counter is 7 bits.
- Size 0 DATA0: both CRC bytes are 0x00.

## Timing
- Reset (async, any state): state IDLE. Every output is 0: load_enable, parallel_out=0x00, timer_enable, get_tx_data, eop_se0, tx_busy, tx_done. Counters are cleared and CRC=0xFFFF. A packet in flight is abandoned with no tx_done.
- Request seen in IDLE at edge k: LOAD during cycle k+1 (load_enable, timer_enable, tx_busy all rise).
- 8th strobe at edge m: next LOAD during cycle m+1. The shifter is loaded before the next strobe. This relies on the timer guaranteeing at least 2 clocks between strobes.
- Strobes in the same cycle as LOAD cannot occur, because the timer restarts from load. If one does occur, it is ignored.
- Stuffed bits produce no strobe, so byte boundaries are unaffected by stuffing.
- EOP_J's strobe at edge e: DONE in cycle e+1, IDLE in cycle e+2.

## Structure
- Shared package usb_tx_pkg holds:
  - tx_packet encodings
  - the state and field enums
  - SYNC/PID byte constants
  - CRC16_INIT=0xFFFF and CRC16_POLY_REFL=0xA001
- Sub-module crc16_byte (combinational): one-byte CRC-16/USB update, crc_in[15:0] and data[7:0] → crc_out[15:0]. The controller instantiates it once.

## Test plan
- ACK request: loads 0x80, then 0xD2; 16 strobes later eop_se0 is high for 2 strobes; then 1 J strobe; tx_done pulses once; no get_tx_data.
- NAK request: second load byte is 0x5A. tx_packet toggled to 01 mid-packet has no effect.
- DATA0, size 0: load sequence 0x80, 0xC3, 0x00, 0x00; zero pops.
- DATA0, size 9, FIFO holds 0x31..0x39 ("123456789"): 9 pops, each coincident with a load of the matching byte; CRC loads are 0xC8 then 0xB4.
- DATA0, tx_packet_size=100: exactly 64 pops before the CRC loads. Strobes stalled by stuffing (gaps of varying length) do not change the byte order.
- n_rst asserted during payload byte 5: all outputs are 0 immediately and asynchronously. After release, an ACK request completes normally with the correct CRC reset.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared encodings for the USB transmit packet sequencer: request codes,
// FSM/field enums, fixed SYNC/PID bytes and CRC-16/USB constants.
package usb_tx_pkg;

  localparam logic [1:0] PKT_NONE  = 2'b00;
  localparam logic [1:0] PKT_DATA0 = 2'b01;
  localparam logic [1:0] PKT_ACK   = 2'b10;
  localparam logic [1:0] PKT_NAK   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_SEND, ST_EOP_SE0, ST_EOP_J, ST_DONE
  } tx_state_e;

  typedef enum logic [2:0] {
    FLD_SYNC, FLD_PID, FLD_DATA, FLD_CRC_LO, FLD_CRC_HI
  } tx_field_e;

  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;

  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;

  function automatic logic [6:0] clamp_size(input logic [6:0] sz, input logic [6:0] lim);
    return (sz > lim) ? lim : sz;
  endfunction

endpackage

// File: rtl/crc16_byte.sv
// One-byte CRC-16/USB update (reflected 0xA001, data LSB first), purely
// combinational: eight unrolled bit steps.
module crc16_byte
  import usb_tx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [8:0][15:0] stage;

  assign stage[0] = crc_in;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign stage[i+1] = (stage[i][0] ^ data[i]) ? ({1'b0, stage[i][15:1]} ^ CRC16_POLY_REFL)
                                                : {1'b0, stage[i][15:1]};
  end

  assign crc_out = stage[8];

endmodule

// File: rtl/usb_tx_ctrl.sv
// USB TX packet sequencer: feeds the shifter SYNC, PID, FIFO payload, CRC16
// and then drives the EOP, counting timer strobes to find byte boundaries.
module usb_tx_ctrl
  import usb_tx_pkg::*;
#(
  parameter int MAX_PAYLOAD = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] tx_packet,
  input  logic [6:0] tx_packet_size,
  input  logic [7:0] packet_data,
  input  logic       shift_strobe,
  output logic       load_enable,
  output logic [7:0] parallel_out,
  output logic       timer_enable,
  output logic       get_tx_data,
  output logic       eop_se0,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [6:0] MAX_P = 7'(MAX_PAYLOAD);

  tx_state_e   state_q, state_d;
  tx_field_e   field_q, field_d;
  logic [1:0]  ptype_q, ptype_d;
  logic [6:0]  remain_q, remain_d;
  logic [2:0]  bit_q, bit_d;
  logic [15:0] crc_q, crc_d;
  logic [15:0] crc_next;

  crc16_byte u_crc (
    .crc_in  (crc_q),
    .data    (packet_data),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= ST_IDLE;
      field_q  <= FLD_SYNC;
      ptype_q  <= PKT_NONE;
      remain_q <= '0;
      bit_q    <= '0;
      crc_q    <= CRC16_INIT;
    end else begin
      state_q  <= state_d;
      field_q  <= field_d;
      ptype_q  <= ptype_d;
      remain_q <= remain_d;
      bit_q    <= bit_d;
      crc_q    <= crc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    field_d      = field_q;
    ptype_d      = ptype_q;
    remain_d     = remain_q;
    bit_d        = bit_q;
    crc_d        = crc_q;
    load_enable  = 1'b0;
    parallel_out = 8'h00;
    timer_enable = 1'b0;
    get_tx_data  = 1'b0;
    eop_se0      = 1'b0;
    tx_done      = 1'b0;
    tx_busy      = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (tx_packet != PKT_NONE) begin
          ptype_d  = tx_packet;
          remain_d = (tx_packet == PKT_DATA0) ? clamp_size(tx_packet_size, MAX_P) : 7'd0;
          crc_d    = CRC16_INIT;
          field_d  = FLD_SYNC;
          bit_d    = 3'd0;
          state_d  = ST_LOAD;
        end
      end

      // Strobes are not expected here since the timer restarts on load.
      ST_LOAD: begin
        load_enable  = 1'b1;
        timer_enable = 1'b1;
        bit_d        = 3'd0;
        state_d      = ST_SEND;
        case (field_q)
          FLD_SYNC: parallel_out = SYNC_BYTE;
          FLD_PID: begin
            case (ptype_q)
              PKT_DATA0: parallel_out = PID_DATA0;
              PKT_ACK:   parallel_out = PID_ACK;
              PKT_NAK:   parallel_out = PID_NAK;
              default:   parallel_out = 8'h00;
            endcase
          end
          FLD_DATA: begin
            parallel_out = packet_data;
            get_tx_data  = 1'b1;
            crc_d        = crc_next;
            remain_d     = remain_q - 7'd1;
          end
          FLD_CRC_LO: parallel_out = ~crc_q[7:0];
          FLD_CRC_HI: parallel_out = ~crc_q[15:8];
          default:    parallel_out = 8'h00;
        endcase
      end

      ST_SEND: begin
        timer_enable = 1'b1;
        if (shift_strobe) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = ST_LOAD;
            case (field_q)
              FLD_SYNC: field_d = FLD_PID;
              FLD_PID: begin
                if (ptype_q == PKT_DATA0) field_d = (remain_q != 7'd0) ? FLD_DATA : FLD_CRC_LO;
                else                      state_d = ST_EOP_SE0;
              end
              FLD_DATA:   field_d = (remain_q != 7'd0) ? FLD_DATA : FLD_CRC_LO;
              FLD_CRC_LO: field_d = FLD_CRC_HI;
              FLD_CRC_HI: state_d = ST_EOP_SE0;
              default:    state_d = ST_EOP_SE0;
            endcase
          end
        end
      end

      // bit_q wrapped to 0 on the 8th strobe, so it counts SE0 bit times here.
      ST_EOP_SE0: begin
        timer_enable = 1'b1;
        eop_se0      = 1'b1;
        if (shift_strobe) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd1) begin
            bit_d   = 3'd0;
            state_d = ST_EOP_J;
          end
        end
      end

      ST_EOP_J: begin
        timer_enable = 1'b1;
        if (shift_strobe) state_d = ST_DONE;
      end

      ST_DONE: begin
        tx_done = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_usb_tx_ctrl.sv
// Randomized-strobe bench for usb_tx_ctrl: per-packet expected byte streams
// come from a queue model and a bitwise CRC-16/USB reference.
module tb_usb_tx_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [1:0] tx_packet;
  logic [6:0] tx_packet_size;
  logic [7:0] packet_data;
  logic       shift_strobe;
  logic       load_enable, timer_enable, get_tx_data, eop_se0, tx_busy, tx_done;
  logic [7:0] parallel_out;

  int total = 0;
  int bad   = 0;

  logic [7:0] fifo[$];
  int         fidx;
  logic [7:0] got[$];

  usb_tx_ctrl #(.MAX_PAYLOAD(64)) dut (
    .clk(clk), .n_rst(n_rst), .tx_packet(tx_packet), .tx_packet_size(tx_packet_size),
    .packet_data(packet_data), .shift_strobe(shift_strobe), .load_enable(load_enable),
    .parallel_out(parallel_out), .timer_enable(timer_enable), .get_tx_data(get_tx_data),
    .eop_se0(eop_se0), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_crc(input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ fifo[i][b];
        c  = {1'b0, c[15:1]} ^ (fb ? 16'hA001 : 16'h0000);
      end
    return c;
  endfunction

  task automatic set_head();
    packet_data = (fidx < fifo.size()) ? fifo[fidx] : 8'h00;
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if (load_enable !== 1'b0 || parallel_out !== 8'h00 || timer_enable !== 1'b0 ||
        get_tx_data !== 1'b0 || eop_se0 !== 1'b0 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      bad++;
      $display("FAIL %s: outputs le=%b po=%h te=%b get=%b se0=%b busy=%b done=%b, all must be 0",
               name, load_enable, parallel_out, timer_enable, get_tx_data, eop_se0, tx_busy, tx_done);
    end
  endtask

  // Called in the #1 slot after a clock edge with the DUT idle.
  task automatic run_packet(input logic [1:0] ptype, input logic [6:0] size, input bit toggle,
                            input int abort_pops, input string name);
    logic [7:0] exp[$];
    logic [7:0] exp_b;
    logic [15:0] crc;
    int n, pops, se0_str, j_str, j_cyc, done_cnt, done_cyc, wcnt;
    bit pop_pend;
    n = 0; pops = 0; se0_str = 0; j_str = 0; j_cyc = -10; done_cnt = 0; done_cyc = -1;
    wcnt = 0; pop_pend = 0;

    exp.push_back(8'h80);
    case (ptype)
      2'b01:   exp.push_back(8'hC3);
      2'b10:   exp.push_back(8'hD2);
      default: exp.push_back(8'h5A);
    endcase
    if (ptype == 2'b01) begin
      n = (size > 7'd64) ? 64 : int'(size);
      for (int i = 0; i < n; i++) exp.push_back(fifo[i]);
      crc = ref_crc(n);
      exp.push_back(~crc[7:0]);
      exp.push_back(~crc[15:8]);
    end

    got.delete();
    fidx = 0;
    set_head();
    tx_packet      = ptype;
    tx_packet_size = size;

    for (int c = 0; c < 8000 && done_cnt == 0; c++) begin
      @(posedge clk); #1;
      if (c == 0) tx_packet = 2'b00;
      if (pop_pend) begin fidx++; set_head(); pop_pend = 0; end

      if (c == 0) begin
        total++;
        if (load_enable !== 1'b1 || parallel_out !== 8'h80 || tx_busy !== 1'b1 || timer_enable !== 1'b1) begin
          bad++;
          $display("FAIL %s first_load: le=%b po=%h busy=%b te=%b, need 1 80 1 1",
                   name, load_enable, parallel_out, tx_busy, timer_enable);
        end
      end

      if (toggle) tx_packet = (got.size() >= 2 && se0_str == 0 && eop_se0 !== 1'b1) ? 2'b01 : 2'b00;

      if (abort_pops > 0 && pops >= abort_pops && load_enable !== 1'b1) begin
        shift_strobe = 1'b0;
        #2 n_rst = 1'b0;
        #1 check_all_zero({name, " async_reset"});
        return;
      end

      if (load_enable === 1'b1) got.push_back(parallel_out);
      if (get_tx_data === 1'b1) begin
        pops++;
        pop_pend = 1;
        exp_b = (fidx < fifo.size()) ? fifo[fidx] : 8'h00;
        total++;
        if (load_enable !== 1'b1 || parallel_out !== exp_b || fidx >= n) begin
          bad++;
          $display("FAIL %s pop%0d: le=%b po=%h, need load of %h within %0d bytes",
                   name, pops, load_enable, parallel_out, exp_b, n);
        end
      end
      if (tx_done === 1'b1) begin done_cnt++; done_cyc = c; end

      if (load_enable === 1'b1) begin
        shift_strobe = 1'b0;
        wcnt = $urandom_range(1, 4);
      end else if (timer_enable === 1'b1 && wcnt == 0) begin
        shift_strobe = 1'b1;
        wcnt = $urandom_range(1, 5);
        if (eop_se0 === 1'b1) se0_str++;
        else if (se0_str > 0) begin j_str++; j_cyc = c; end
      end else begin
        shift_strobe = 1'b0;
        if (wcnt > 0) wcnt--;
      end
    end
    shift_strobe = 1'b0;
    tx_packet    = 2'b00;

    total++;
    if (done_cnt != 1 || done_cyc != j_cyc + 1) begin
      bad++;
      $display("FAIL %s done: count=%0d cycle=%0d, need 1 at cycle %0d", name, done_cnt, done_cyc, j_cyc + 1);
    end
    total++;
    if (se0_str != 2 || j_str != 1) begin
      bad++;
      $display("FAIL %s eop: se0 strobes=%0d j strobes=%0d, need 2 and 1", name, se0_str, j_str);
    end
    total++;
    if (pops != n) begin
      bad++;
      $display("FAIL %s pops: got %0d need %0d", name, pops, n);
    end
    total++;
    if (got.size() != exp.size()) begin
      bad++;
      $display("FAIL %s load_count: got %0d need %0d", name, got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++)
        if (got[i] !== exp[i]) begin
          bad++;
          $display("FAIL %s load_byte[%0d]: got %h need %h", name, i, got[i], exp[i]);
          break;
        end
    end

    @(posedge clk); #1;
    total++;
    if (tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      bad++;
      $display("FAIL %s back_to_idle: busy=%b done=%b need 0 0", name, tx_busy, tx_done);
    end
  endtask

  task automatic fill_random(input int cnt);
    fifo.delete();
    for (int i = 0; i < cnt; i++) fifo.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic test_reset();
    n_rst = 1'b0; tx_packet = 2'b00; tx_packet_size = '0; packet_data = '0; shift_strobe = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_ack();
    fifo.delete();
    run_packet(2'b10, 7'd0, 1'b0, 0, "ack");
  endtask

  task automatic test_nak_toggle();
    fifo.delete();
    run_packet(2'b11, 7'd5, 1'b1, 0, "nak_toggle");
  endtask

  task automatic test_zero_len();
    fifo.delete();
    run_packet(2'b01, 7'd0, 1'b0, 0, "data0_len0");
  endtask

  task automatic test_crc_vector();
    fifo.delete();
    for (int i = 0; i < 9; i++) fifo.push_back(8'h31 + 8'(i));
    run_packet(2'b01, 7'd9, 1'b0, 0, "data0_123456789");
    total++;
    if (got.size() != 13 || got[11] !== 8'hC8 || got[12] !== 8'hB4) begin
      bad++;
      $display("FAIL crc_vector: loads=%0d crc bytes %h %h need C8 B4", got.size(),
               (got.size() > 11) ? got[11] : 8'hxx, (got.size() > 12) ? got[12] : 8'hxx);
    end
  endtask

  task automatic test_clamp();
    fill_random(100);
    run_packet(2'b01, 7'd100, 1'b0, 0, "data0_clamp");
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      fill_random(20);
      run_packet(2'b01, 7'($urandom_range(1, 20)), 1'b0, 0, "data0_rand");
    end
  endtask

  task automatic test_back_to_back();
    fifo.delete();
    run_packet(2'b10, 7'd0, 1'b0, 0, "b2b_ack");
    fill_random(3);
    run_packet(2'b01, 7'd3, 1'b0, 0, "b2b_data0");
    run_packet(2'b11, 7'd0, 1'b0, 0, "b2b_nak");
  endtask

  task automatic test_abort();
    fill_random(12);
    run_packet(2'b01, 7'd12, 1'b0, 5, "abort");
    repeat (2) @(posedge clk);
    #1 check_all_zero("abort_held");
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); #1;
    fifo.delete();
    run_packet(2'b10, 7'd0, 1'b0, 0, "after_abort_ack");
    fifo.delete();
    for (int i = 0; i < 9; i++) fifo.push_back(8'h31 + 8'(i));
    run_packet(2'b01, 7'd9, 1'b0, 0, "after_abort_crc");
  endtask

  initial begin
    test_reset();
    test_ack();
    test_nak_toggle();
    test_zero_len();
    test_crc_vector();
    test_clamp();
    test_random();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
